// File: rtl/traffic_light_ctrl_n.sv
// traffic_light_ctrl_n: N-way intersection controller serving one direction at a time,
// with latched pedestrian walk phase and a parade hold that freezes the current green.
module traffic_light_ctrl_n #(
    parameter int NUM_DIR    = 4,
    parameter int GREEN_MIN  = 4,
    parameter int GREEN_MAX  = 16,
    parameter int YELLOW_CYC = 2,
    parameter int ALLRED_CYC = 1,
    parameter int WALK_CYC   = 6,
    parameter int TW         = 8,
    localparam int DW        = $clog2(NUM_DIR)
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [NUM_DIR-1:0]   i_traffic,
    input  logic                 i_ped,
    input  logic                 i_P,
    input  logic                 i_R,
    output logic [2*NUM_DIR-1:0] o_light,
    output logic [DW-1:0]        o_dir,
    output logic                 o_walk,
    output logic                 o_parade
);
    typedef enum logic [1:0] {GREEN, YELLOW, ALLRED, WALK} state_t;
    state_t state, nstate;
    logic [DW-1:0] cur, nxt_cur, idx;
    logic [TW-1:0] timer;
    logic ped_pend, parade, found, other_req, go;

    // round-robin pick: first waiting direction after cur, cur itself never chosen
    always_comb begin
        nxt_cur = cur;
        idx = cur;
        found = 1'b0;
        for (int i = 1; i < NUM_DIR; i++) begin
            idx = (idx == DW'(NUM_DIR - 1)) ? '0 : idx + DW'(1);
            if (!found && i_traffic[idx]) begin
                nxt_cur = idx;
                found = 1'b1;
            end
        end
    end

    assign other_req = (|(i_traffic & ~(NUM_DIR'(1) << cur))) | ped_pend;
    assign go = !parade && other_req && timer >= TW'(GREEN_MIN - 1) &&
                (!i_traffic[cur] || timer >= TW'(GREEN_MAX - 1));

    always_comb begin
        nstate = state;
        case (state)
            GREEN:   nstate = go ? YELLOW : GREEN;
            YELLOW:  nstate = (timer == TW'(YELLOW_CYC - 1)) ? ALLRED : YELLOW;
            ALLRED:  nstate = (timer != TW'(ALLRED_CYC - 1)) ? ALLRED : ped_pend ? WALK : GREEN;
            default: nstate = (timer == TW'(WALK_CYC - 1)) ? GREEN : WALK;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state    <= GREEN;
            cur      <= '0;
            timer    <= '0;
            ped_pend <= 1'b0;
            parade   <= 1'b0;
        end else begin
            state    <= nstate;
            timer    <= (nstate != state) ? '0 :
                        (state == GREEN && timer == TW'(GREEN_MAX - 1)) ? timer : timer + TW'(1);
            cur      <= (nstate == GREEN && state != GREEN) ? nxt_cur : cur;
            ped_pend <= (nstate == WALK || state == WALK) ? 1'b0 : ped_pend | i_ped;
            parade   <= i_R ? 1'b0 : (i_P | parade);
        end
    end

    always_comb begin
        o_light = '0;
        for (int k = 0; k < NUM_DIR; k++)
            o_light[2*k +: 2] = (DW'(k) != cur) ? 2'd2 :
                                (state == GREEN) ? 2'd0 : (state == YELLOW) ? 2'd1 : 2'd2;
    end

    assign o_dir    = cur;
    assign o_walk   = (state == WALK);
    assign o_parade = parade;
endmodule

// File: tb/tb_traffic_light_ctrl_n.sv
// tb_traffic_light_ctrl_n: directed scenarios plus randomized run against a phase/duration model.
module tb_traffic_light_ctrl_n;
    localparam int GMIN = 4, GMAX = 16, YC = 2, AC = 1, WC = 6;
    localparam logic [7:0] G0 = 8'hA8, Y0 = 8'hA9, AR = 8'hAA, G1 = 8'hA2, G2 = 8'h8A, G3 = 8'h2A;

    logic clk = 1'b0;
    logic rst, ped, p_set, r_rel;
    logic [3:0] traffic;
    logic [7:0] light;
    logic [1:0] dir;
    logic walk, parade;
    int checks = 0, errors = 0;

    // model: phase 0 green, 1 yellow, 2 all-red, 3 walk; m_t counts cycles spent in phase
    int m_ph, m_t, m_dir;
    bit m_pend, m_par;

    traffic_light_ctrl_n dut (
        .i_clk(clk), .i_rst(rst), .i_traffic(traffic), .i_ped(ped), .i_P(p_set), .i_R(r_rel),
        .o_light(light), .o_dir(dir), .o_walk(walk), .o_parade(parade)
    );

    always #5 clk = ~clk;

    function automatic int pick(input logic [3:0] tr);
        for (int s = 1; s < 4; s++)
            if (tr[(m_dir + s) % 4]) return (m_dir + s) % 4;
        return m_dir;
    endfunction

    function automatic logic [11:0] model_out();
        logic [7:0] l;
        l = AR;
        if (m_ph == 0) l[2*m_dir +: 2] = 2'd0;
        if (m_ph == 1) l[2*m_dir +: 2] = 2'd1;
        return {l, 2'(m_dir), m_ph == 3, m_par};
    endfunction

    task automatic model_step(input logic [3:0] tr, input bit pd, input bit p, input bit r, input bit rs);
        int nph, nd;
        bit others;
        if (rs) begin
            m_ph = 0; m_t = 0; m_dir = 0; m_pend = 0; m_par = 0;
            return;
        end
        others = ((tr & ~(4'b1 << m_dir)) != 0) || m_pend;
        nph = m_ph;
        nd = m_dir;
        if (m_ph == 0 && !m_par && others && m_t >= GMIN - 1 && (!tr[m_dir] || m_t >= GMAX - 1)) nph = 1;
        if (m_ph == 1 && m_t == YC - 1) nph = 2;
        if (m_ph == 2 && m_t == AC - 1) nph = m_pend ? 3 : 0;
        if (m_ph == 3 && m_t == WC - 1) nph = 0;
        if (nph == 0 && m_ph != 0) nd = pick(tr);
        m_pend = (nph == 3 || m_ph == 3) ? 1'b0 : (m_pend | pd);
        m_par = r ? 1'b0 : (p | m_par);
        m_t = (nph != m_ph) ? 0 : m_t + 1;
        m_ph = nph;
        m_dir = nd;
    endtask

    task automatic tick(input logic [3:0] tr, input bit pd, input bit p, input bit r, input bit rs);
        traffic = tr; ped = pd; p_set = p; r_rel = r; rst = rs;
        model_step(tr, pd, p, r, rs);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        tick(4'b1111, 1, 1, 0, 1);
        checks += 4;
        if (light !== G0) begin errors++; $display("FAIL reset_light got %h want %h", light, G0); end
        if (dir !== 2'd0) begin errors++; $display("FAIL reset_dir got %0d want 0", dir); end
        if (walk !== 1'b0) begin errors++; $display("FAIL reset_walk got %b want 0", walk); end
        if (parade !== 1'b0) begin errors++; $display("FAIL reset_parade got %b want 0", parade); end
    endtask

    task automatic test_min_green();
        logic [7:0] seq [8] = '{G0, G0, G0, G0, Y0, Y0, AR, G2};
        tick(4'b0100, 0, 0, 0, 1);
        for (int i = 0; i < 8; i++) begin
            if (i > 0) tick(4'b0100, 0, 0, 0, 0);
            checks++;
            if (light !== seq[i]) begin errors++; $display("FAIL min_green cyc%0d got %h want %h", i, light, seq[i]); end
        end
        checks++;
        if (dir !== 2'd2) begin errors++; $display("FAIL min_green_dir got %0d want 2", dir); end
    endtask

    task automatic test_max_green();
        int bad = 0;
        logic [7:0] e;
        tick(4'b0011, 0, 0, 0, 1);
        for (int i = 0; i < 20; i++) begin
            if (i > 0) tick(4'b0011, 0, 0, 0, 0);
            e = (i < 16) ? G0 : (i < 18) ? Y0 : (i == 18) ? AR : G1;
            if (light !== e) begin bad++; $display("FAIL max_green cyc%0d got %h want %h", i, light, e); end
        end
        checks += 2;
        if (bad != 0) errors++;
        if (dir !== 2'd1) begin errors++; $display("FAIL max_green_dir got %0d want 1", dir); end
    endtask

    task automatic test_wrap();
        int n = 0, bad = 0;
        tick(4'b1000, 0, 0, 0, 1);
        while (dir !== 2'd3 && n < 20) begin tick(4'b1000, 0, 0, 0, 0); n++; end
        checks++;
        if (dir !== 2'd3) begin errors++; $display("FAIL wrap_reach3 got %0d want 3", dir); end
        for (int i = 0; i < 30; i++) begin
            tick(4'b1000, 0, 0, 0, 0);
            if (light !== G3) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL wrap_hold3 bad_cycles %0d want 0", bad); end
        n = 0;
        while (dir === 2'd3 && n < 20) begin tick(4'b0010, 0, 0, 0, 0); n++; end
        checks += 2;
        if (dir !== 2'd1) begin errors++; $display("FAIL wrap_next got %0d want 1", dir); end
        if (light !== G1) begin errors++; $display("FAIL wrap_light got %h want %h", light, G1); end
    endtask

    task automatic test_ped();
        int n = 0, bad = 0, walks = 0;
        tick(4'b0000, 0, 0, 0, 1);
        tick(4'b0000, 1, 0, 0, 0);
        while (!walk && n < 20) begin tick(4'b0000, 0, 0, 0, 0); n++; end
        checks++;
        if (walk !== 1'b1) begin errors++; $display("FAIL ped_walk_start got %b want 1", walk); end
        n = 0;
        while (walk === 1'b1 && n < 20) begin
            if (light !== AR) bad++;
            n++;
            tick(4'b0000, n == 2, 0, 0, 0);
        end
        checks += 3;
        if (n != WC) begin errors++; $display("FAIL ped_walk_len got %0d want %0d", n, WC); end
        if (bad != 0) begin errors++; $display("FAIL ped_walk_red bad_cycles %0d want 0", bad); end
        if (light !== G0 || dir !== 2'd0) begin errors++; $display("FAIL ped_return got %h/%0d want %h/0", light, dir, G0); end
        for (int i = 0; i < 30; i++) begin
            tick(4'b0000, 0, 0, 0, 0);
            if (walk) walks++;
        end
        checks++;
        if (walks != 0) begin errors++; $display("FAIL ped_second_walk got %0d want 0", walks); end
    endtask

    task automatic test_parade();
        int bad = 0;
        tick(4'b1110, 0, 0, 0, 1);
        tick(4'b1110, 0, 1, 0, 0);
        for (int i = 0; i < 120; i++) begin
            if (light !== G0 || parade !== 1'b1) bad++;
            tick(4'b1110, i == 50, 0, 0, 0);
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL parade_hold bad_cycles %0d want 0", bad); end
        tick(4'b1110, 0, 1, 1, 0);
        checks += 2;
        if (parade !== 1'b0) begin errors++; $display("FAIL parade_release got %b want 0", parade); end
        if (light !== G0) begin errors++; $display("FAIL parade_release_light got %h want %h", light, G0); end
        tick(4'b1110, 0, 0, 0, 0);
        checks++;
        if (light !== Y0) begin errors++; $display("FAIL parade_yellow got %h want %h", light, Y0); end
    endtask

    task automatic test_reset_midphase();
        int n = 0;
        tick(4'b0000, 0, 0, 0, 1);
        tick(4'b0000, 1, 0, 0, 0);
        while (!walk && n < 20) begin tick(4'b0000, 0, 0, 0, 0); n++; end
        tick(4'b0000, 0, 0, 0, 0);
        tick(4'b0110, 1, 1, 0, 1);
        checks += 2;
        if (light !== G0 || dir !== 2'd0 || walk !== 1'b0) begin errors++; $display("FAIL rst_in_walk got %h/%0d/%b want %h/0/0", light, dir, walk, G0); end
        if (parade !== 1'b0) begin errors++; $display("FAIL rst_in_walk_parade got %b want 0", parade); end
        n = 0;
        while (light !== Y0 && n < 20) begin tick(4'b0010, 0, 0, 0, 0); n++; end
        tick(4'b0010, 0, 0, 0, 1);
        checks++;
        if (light !== G0 || dir !== 2'd0 || walk !== 1'b0) begin errors++; $display("FAIL rst_in_yellow got %h/%0d/%b want %h/0/0", light, dir, walk, G0); end
    endtask

    task automatic test_random();
        logic [11:0] got;
        tick(4'b0000, 0, 0, 0, 1);
        for (int i = 0; i < 3000; i++) begin
            tick(4'($urandom), $urandom_range(15) == 0, $urandom_range(60) == 0,
                 $urandom_range(25) == 0, $urandom_range(400) == 0);
            got = {light, dir, walk, parade};
            checks++;
            if (got !== model_out()) begin
                errors++;
                $display("FAIL random cyc%0d got %h want %h", i, got, model_out());
            end
        end
    endtask

    initial begin
        traffic = '0; ped = 0; p_set = 0; r_rel = 0; rst = 1;
        test_reset();
        test_min_green();
        test_max_green();
        test_wrap();
        test_ped();
        test_parade();
        test_reset_midphase();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/traffic_light_ctrl_n.md
TRAFFIC_LIGHT_CTRL_N -- requirements
Module: traffic_light_ctrl_n

Interface
REQ-001 The block SHALL have parameter NUM_DIR, default 4, number of approach directions (legal 2..8).
REQ-002 The block SHALL have parameter GREEN_MIN, default 4, minimum green cycles (>=1).
REQ-003 The block SHALL have parameter GREEN_MAX, default 16, max green cycles while others wait (>=GREEN_MIN).
REQ-004 The block SHALL have parameters YELLOW_CYC, default 2; ALLRED_CYC, default 1; WALK_CYC, default 6 (each >=1).
REQ-005 The block SHALL have parameter TW, default 8, phase-timer width; all cycle parameters <= 2^TW-1.
REQ-006 The block SHALL have one clock and a synchronous, active-high reset: i_clk  input  1  clock, rising edge; i_rst  input  1  synchronous active-high reset.
REQ-007 The block SHALL have i_traffic  input  NUM_DIR  per-direction car sensor, bit k = traffic waiting at direction k.
REQ-008 The block SHALL have i_ped  input  1  pedestrian request, level or pulse, latched.
REQ-009 The block SHALL have i_P  input  1  parade set; i_R  input  1  parade release.
REQ-010 The block SHALL have o_light  output  2*NUM_DIR  per-direction colour, field k at [2k+1:2k]: 0 GREEN, 1 YELLOW, 2 RED, 3 never driven.
REQ-011 The block SHALL have o_dir  output  $clog2(NUM_DIR)  index of the current served direction; o_walk  output  1  pedestrian walk; o_parade  output  1  parade mode active.

Function
REQ-012 The phase FSM SHALL have states GREEN, YELLOW, ALLRED, WALK; outputs SHALL be Moore-decoded from registered state, cur and mode.
REQ-013 o_light SHALL be: GREEN -> field cur=0, rest 2; YELLOW -> field cur=1, rest 2; ALLRED/WALK -> all 2; o_walk=1 only in WALK.
REQ-014 The phase timer SHALL clear to 0 on every state entry, increment each cycle in-state, and saturate at GREEN_MAX-1 in GREEN.
REQ-015 other_req SHALL be (|(i_traffic with bit cur masked)) OR ped_pend.
REQ-016 GREEN->YELLOW SHALL occur when parade=0 AND other_req AND timer>=GREEN_MIN-1 AND (i_traffic[cur]=0 OR timer>=GREEN_MAX-1); otherwise GREEN holds indefinitely.
REQ-017 YELLOW->ALLRED SHALL occur at timer=YELLOW_CYC-1 (exactly YELLOW_CYC yellow cycles); parade does not abort YELLOW.
REQ-018 ALLRED exit at timer=ALLRED_CYC-1 SHALL go to WALK if ped_pend=1, else to GREEN with cur updated per REQ-020.
REQ-019 WALK exit at timer=WALK_CYC-1 SHALL go to GREEN with cur updated per REQ-020.
REQ-020 Next cur SHALL be the first set bit of i_traffic scanning cur+1, cur+2, ... cyclically (mod NUM_DIR), excluding cur; if none set, cur is retained.
REQ-021 ped_pend SHALL set on any cycle with i_ped=1 and clear on the cycle entering WALK; i_ped during WALK-entry cycle or in WALK SHALL be ignored.
REQ-022 Mode register SHALL set on i_P=1, clear on i_R=1; i_P and i_R both 1 SHALL clear (release wins); o_parade reflects the register.
REQ-023 While parade=1, GREEN SHALL not exit; ped_pend SHALL stay latched and be served after release.
REQ-024 No direction SHALL ever show GREEN or YELLOW while another does; at least one ALLRED cycle SHALL separate any two greens.

Reset
REQ-025 When i_rst=1 at a rising edge, next state SHALL be GREEN, cur=0, timer=0, ped_pend=0, parade=0, regardless of current state.
REQ-026 After reset: o_light field 0=0, all other fields=2, o_dir=0, o_walk=0, o_parade=0.
REQ-027 Reset SHALL take priority over all inputs, including i_P, i_ped, i_traffic.

Verification (defaults, NUM_DIR=4)
REQ-028 Reset, i_traffic=4'b0100 from cycle 0 -> GREEN dir0 4 cycles, YELLOW dir0 2 cycles, ALLRED 1 cycle, then o_dir=2, field 2=GREEN.
REQ-029 i_traffic=4'b0011 held constant, cur=0 -> dir0 held green exactly 16 cycles (GREEN_MAX), then yellow 2, allred 1, o_dir=1.
REQ-030 cur=3, i_traffic=4'b0010 -> next o_dir=1 (wrap-around scan 0 skipped, 1 selected); i_traffic=4'b1000 with cur=3 -> green retained on 3, no yellow.
REQ-031 Single-cycle i_ped pulse during GREEN, no traffic -> yellow, allred, WALK 6 cycles with o_walk=1 and all lights RED, then GREEN on same o_dir; second pulse inside WALK produces no further WALK.
REQ-032 i_P=1 pulse during GREEN with i_traffic=4'b1110 -> green held >100 cycles, o_parade=1; i_P=i_R=1 same cycle -> o_parade=0 and YELLOW follows next cycle.
REQ-033 i_rst=1 asserted for one cycle during WALK and during YELLOW -> next cycle o_light field 0=GREEN, others RED, o_walk=0, o_dir=0.
